// File: rtl/smg_capture_module.sv
// rtl/smg_capture_module.sv - seven-segment scan capture: debounce digits, decode, publish 6-digit frames
module smg_capture_module #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [7:0]  smg_data,
    input  logic [5:0]  scan_sig,
    output logic [23:0] number_sig,
    output logic        frame_valid,
    output logic        code_err,
    output logic        scan_err,
    output logic        link_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYC);
    localparam logic [7:0]    CNT_MAX = 8'(STABLE_CYC - 1);
    localparam logic [7:0]    HIT_VAL = 8'(STABLE_CYC - 2);

    typedef enum logic [1:0] {IDLE, COUNT, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [7:0]      data_s1, data_s2;
    logic [5:0]      scan_s1, scan_s2;
    logic [13:0]     prev_q;
    logic [7:0]      cnt_q;
    logic [5:0]      mask_q, mask_d;
    logic [5:0]      serr_q, serr_d;
    logic [5:0][3:0] slot_q, slot_d;
    logic [TW-1:0]   tcnt_q;

    logic       same, one_cold, multi, hit, accept, scan_err_d, publish;
    logic [2:0] idx;
    logic [4:0] dec;

    function automatic logic [2:0] count_low(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) n = n + {2'b00, ~v[i]};
        return n;
    endfunction

    function automatic logic [2:0] low_index(input logic [5:0] v);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 0; i < 6; i++) if (!v[i]) k = 3'(i);
        return k;
    endfunction

    // Returns {error, nibble}; dp is not part of the digit code.
    function automatic logic [4:0] seg_decode(input logic [6:0] c);
        case (c)
            7'h40:   return 5'h00;
            7'h79:   return 5'h01;
            7'h24:   return 5'h02;
            7'h30:   return 5'h03;
            7'h19:   return 5'h04;
            7'h12:   return 5'h05;
            7'h02:   return 5'h06;
            7'h78:   return 5'h07;
            7'h00:   return 5'h08;
            7'h10:   return 5'h09;
            default: return 5'h1F;
        endcase
    endfunction

    assign same     = ({scan_s2, data_s2} == prev_q);
    assign one_cold = (count_low(scan_s2) == 3'd1);
    assign multi    = (count_low(scan_s2) >= 3'd2);
    assign hit      = same && (cnt_q == HIT_VAL);
    assign idx      = low_index(scan_s2);
    assign dec      = seg_decode(data_s2[6:0]);
    assign publish  = (mask_q == 6'h3F);
    assign link_timeout = (tcnt_q == TMAX);

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        scan_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_cold)          state_d = COUNT;
                else if (multi && hit) scan_err_d = 1'b1;
            end
            COUNT: begin
                if (!same) begin
                    state_d = one_cold ? COUNT : IDLE;
                end else if (hit) begin
                    accept  = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!same) state_d = one_cold ? COUNT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Publication clears the frame first so a same-cycle acceptance starts the next frame.
    always_comb begin
        mask_d = publish ? 6'h00 : mask_q;
        serr_d = publish ? 6'h00 : serr_q;
        slot_d = slot_q;
        if (accept) begin
            mask_d[idx] = 1'b1;
            serr_d[idx] = dec[4];
            slot_d[idx] = dec[3:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            data_s1     <= 8'hFF;
            data_s2     <= 8'hFF;
            scan_s1     <= 6'h3F;
            scan_s2     <= 6'h3F;
            prev_q      <= 14'h3FFF;
            cnt_q       <= 8'd0;
            mask_q      <= 6'h00;
            serr_q      <= 6'h00;
            slot_q      <= '0;
            tcnt_q      <= '0;
            number_sig  <= 24'h000000;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
            scan_err    <= 1'b0;
        end else begin
            data_s1     <= smg_data;
            data_s2     <= data_s1;
            scan_s1     <= scan_sig;
            scan_s2     <= scan_s1;
            prev_q      <= {scan_s2, data_s2};
            if (!same || (state_q == IDLE && one_cold)) cnt_q <= 8'd0;
            else if (cnt_q != CNT_MAX)                  cnt_q <= cnt_q + 8'd1;
            mask_q      <= mask_d;
            serr_q      <= serr_d;
            slot_q      <= slot_d;
            frame_valid <= publish;
            scan_err    <= scan_err_d;
            if (publish) begin
                number_sig <= slot_q;
                code_err   <= |serr_q;
                tcnt_q     <= '0;
            end else if (tcnt_q != TMAX) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
        end
    end

endmodule
